truth_table_scanner: RTL
========================

// Module: truth_table_scanner
// PURPOSE
//  Sequencer that exhaustively drives the 7-input majority-network datapath (one MAJ3 cone, single out bit)
//  with all 128 input minterms and assembles the resulting 128-bit truth table for the classification
//  flow. One minterm is issued per clock. Completed table plus its weight are presented on a valid/ready
//  output. Sits between the classification host and the function datapath under test.
// PARAMETERS
//  LAT     0    pipeline registers in the datapath path x_out->f_in (0..3); 0 = purely combinational
//  N_IN    7    datapath input count; table width is 2**N_IN (only 7 supported)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    asynchronous active-low reset
//  start      in   1    request a scan; accepted only in IDLE
//  abort      in   1    synchronous cancel; returns to IDLE
//  busy       out  1    high in SCAN or DRAIN
//  x_out      out  7    minterm driven to datapath inputs x6..x0 (bit i -> xi)
//  f_in       in   1    datapath output for the minterm issued LAT cycles earlier
//  tt         out  128  truth table; bit k = f(x=k)
//  ones_cnt   out  8    number of set bits in tt (0..128)
//  tt_valid   out  1    tt/ones_cnt valid; held until tt_ready
//  tt_ready   in   1    consumer accepts table
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; x_out=0, busy=0, tt=0, ones_cnt=0, tt_valid=0, all counters 0.
//  FSM IDLE -> SCAN -> DRAIN -> HOLD -> IDLE.
//   IDLE : start=1 -> SCAN next cycle; issue counter=0; tt and ones_cnt cleared on the transition.
//   SCAN : x_out = issue counter; increments by 1 each cycle, 0..127. After issuing 127: -> DRAIN if
//          LAT>0, else -> HOLD.
//   DRAIN: x_out holds 127; wait until LAT outstanding captures complete, then -> HOLD.
//   HOLD : tt_valid=1; tt/ones_cnt stable. tt_valid&tt_ready -> IDLE next cycle, tt_valid falls.
//  Capture: f_in sampled every cycle a minterm issued LAT cycles earlier is in flight. Capture index
//   equals issue counter delayed LAT cycles (shift-register valid tag). tt[idx] <= f_in;
//   ones_cnt += f_in.
//  Latency: start accepted in cycle T -> x_out=0 in T+1 -> tt_valid high in T+129+LAT.
//  start while busy or in HOLD: ignored (no queueing). start and tt_ready together in HOLD: handshake
//   completes, start ignored; new start needed in IDLE.
//  abort (SCAN/DRAIN/HOLD): -> IDLE next cycle; busy=0, tt_valid=0; tt/ones_cnt keep partial contents
//   until the next accepted start. abort has priority over start and tt_ready in the same cycle.
//  ones_cnt is 8 bits so 128 is representable; no wrap. Issue counter is 7 bits and stops at 127.
//  x_out is registered (no glitching into the datapath); f_in is used only at capture.
//  rst_n asserted mid-scan: immediate return to reset values; partial table discarded.
// TESTING
//  T1 f = MAJ(x0,x1,x2), LAT=0, start pulse -> tt=128'hE8E8_..._E8 (16 bytes), ones_cnt=64, tt_valid at
//     T+129.
//  T2 f constant 0 then constant 1 -> tt=0/ones_cnt=0; tt=all-ones/ones_cnt=128 (no overflow).
//  T3 LAT=2, datapath registered 2 stages, f = reference 7-input MAJ cone -> tt identical to LAT=0 run;
//     tt_valid at T+131.
//  T4 tt_ready low 20 cycles in HOLD, start pulsed meanwhile -> tt_valid/tt stable, start ignored,
//     busy=0; ready=1 -> IDLE.
//  T5 rst_n low when x_out=50 -> all outputs at reset values during reset; new scan with f=x6 ->
//     tt=upper 64 bits set, ones_cnt=64.
//  T6 abort at x_out=90 -> IDLE next cycle, busy=0, tt_valid stays 0; subsequent start gives correct
//     full table.

Source files
------------

// File: rtl/truth_table_scanner_if.sv
// Host/datapath bundle for truth_table_scanner.
// slave = scanner side, master = host plus datapath side.
interface truth_table_scanner_if;
    logic         start;
    logic         abort;
    logic         busy;
    logic [6:0]   x_out;
    logic         f_in;
    logic [127:0] tt;
    logic [7:0]   ones_cnt;
    logic         tt_valid;
    logic         tt_ready;

    modport slave (
        input  start, abort, f_in, tt_ready,
        output busy, x_out, tt, ones_cnt, tt_valid
    );

    modport master (
        output start, abort, f_in, tt_ready,
        input  busy, x_out, tt, ones_cnt, tt_valid
    );
endinterface

// File: rtl/truth_table_scanner.sv
// Drives all minterms into a 7-input datapath and assembles its truth table.
// LAT = register stages between x_out and f_in.
module truth_table_scanner #(
    parameter int LAT  = 0,
    parameter int N_IN = 7
) (
    input logic              clk,
    input logic              rst_n,
    truth_table_scanner_if.slave bus
);
    localparam int TW = 1 << N_IN;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, HOLD} state_e;

    state_e          state_q, state_d;
    logic [N_IN-1:0] x_q, x_d;
    logic [TW-1:0]   tt_q, tt_d;
    logic [7:0]      ones_q, ones_d;
    logic            issue;
    logic            cap_vld;
    logic [N_IN-1:0] cap_idx;
    logic            kill;

    assign issue = (state_q == SCAN);
    assign kill  = bus.abort && (state_q != IDLE);

    // Valid tag travels alongside each minterm for LAT cycles
    if (LAT == 0) begin : g_comb
        assign cap_vld = issue;
        assign cap_idx = x_q;
    end else begin : g_pipe
        logic [LAT-1:0]  vld_q, vld_d;
        logic [N_IN-1:0] idx_q [LAT];
        logic [N_IN-1:0] idx_d [LAT];

        always_comb begin
            vld_d    = '0;
            vld_d[0] = issue && !kill;
            idx_d[0] = x_q;
            for (int i = 1; i < LAT; i++) begin
                vld_d[i] = vld_q[i-1] && !kill;
                idx_d[i] = idx_q[i-1];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
            end else begin
                vld_q <= vld_d;
                for (int i = 0; i < LAT; i++) idx_q[i] <= idx_d[i];
            end
        end

        assign cap_vld = vld_q[LAT-1];
        assign cap_idx = idx_q[LAT-1];
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        tt_d    = tt_q;
        ones_d  = ones_q;
        if (cap_vld) begin
            tt_d[cap_idx] = bus.f_in;
            ones_d        = ones_q + 8'(bus.f_in);
        end
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SCAN;
                    x_d     = '0;
                    tt_d    = '0;
                    ones_d  = '0;
                end
            end
            SCAN: begin
                if (x_q == '1) state_d = (LAT > 0) ? DRAIN : HOLD;
                else           x_d = x_q + 1'b1;
            end
            DRAIN: begin
                if (cap_vld && cap_idx == '1) state_d = HOLD;
            end
            HOLD: begin
                if (bus.tt_ready) begin
                    state_d = IDLE;
                    x_d     = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            x_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            tt_q    <= '0;
            ones_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tt_q    <= tt_d;
            ones_q  <= ones_d;
        end
    end

    assign bus.busy     = (state_q == SCAN) || (state_q == DRAIN);
    assign bus.tt_valid = (state_q == HOLD);
    assign bus.x_out    = x_q;
    assign bus.tt       = tt_q;
    assign bus.ones_cnt = ones_q;
endmodule
